// File: rtl/bnn_pkg.sv
// Shared types, width helpers and default sizes for the BNN inference engine.
package bnn_pkg;

    // Default network shape, shared with the feature binariser.
    localparam int unsigned DEF_N_IN   = 4;
    localparam int unsigned DEF_N_HID  = 4;
    localparam int unsigned DEF_N_OUT  = 2;
    localparam int unsigned DEF_BIAS_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHid  = 2'd1,
        StOut  = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Popcount width: enough bits to hold the largest fan-in count.
    function automatic int unsigned calc_cw(input int unsigned n_in, input int unsigned n_hid);
        return $clog2(max_u(n_in, n_hid) + 1);
    endfunction

    // Score width: popcount plus bias can never overflow at this width.
    function automatic int unsigned calc_sw(input int unsigned n_in, input int unsigned n_hid,
                                            input int unsigned bias_w);
        return max_u(calc_cw(n_in, n_hid), bias_w) + 2;
    endfunction

    // Index width for n items, never less than one bit.
    function automatic int unsigned calc_iw(input int unsigned n);
        return max_u(1, $clog2(n));
    endfunction

endpackage

// File: rtl/bnn_seq_engine_if.sv
// Handshake, configuration and result bundle of the BNN inference engine.
interface bnn_seq_engine_if
    import bnn_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned N_HID  = DEF_N_HID,
    parameter int unsigned N_OUT  = DEF_N_OUT,
    parameter int unsigned BIAS_W = DEF_BIAS_W
) ();

    localparam int unsigned SW  = calc_sw(N_IN, N_HID, BIAS_W);
    localparam int unsigned CIW = calc_iw(N_OUT);

    logic                      start;
    logic [N_IN-1:0]           in_vec;
    logic [N_HID*N_IN-1:0]     w_ih;
    logic [N_HID*BIAS_W-1:0]   b_h;
    logic [N_OUT*N_HID-1:0]    w_ho;
    logic [N_OUT*BIAS_W-1:0]   b_o;

    logic                      busy;
    logic                      done;
    logic                      valid;
    logic [N_HID-1:0]          hidden;
    logic [N_OUT-1:0]          out_act;
    logic [CIW-1:0]            class_idx;
    logic signed [SW-1:0]      class_score;

    modport master (
        output start, in_vec, w_ih, b_h, w_ho, b_o,
        input  busy, done, valid, hidden, out_act, class_idx, class_score
    );

    modport slave (
        input  start, in_vec, w_ih, b_h, w_ho, b_o,
        output busy, done, valid, hidden, out_act, class_idx, class_score
    );

endinterface

// File: rtl/bnn_xnor_popcount.sv
// XNOR of a against w, counted over the bits enabled by mask.
module bnn_xnor_popcount #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             w,
    input  logic [WIDTH-1:0]             mask,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] match;

    // Masked-off bits read as mismatches so they never add to the count.
    always_comb begin
        match = ~(a ^ w) & mask;
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNTW'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_seq_engine.sv
// Time-multiplexed BNN engine: one neuron per cycle through a shared XNOR/popcount,
// hidden layer first, then output layer with running argmax.
module bnn_seq_engine
    import bnn_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned N_HID  = DEF_N_HID,
    parameter int unsigned N_OUT  = DEF_N_OUT,
    parameter int unsigned BIAS_W = DEF_BIAS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    bnn_seq_engine_if.slave      bus
);

    localparam int unsigned CW  = calc_cw(N_IN, N_HID);
    localparam int unsigned SW  = calc_sw(N_IN, N_HID, BIAS_W);
    localparam int unsigned PW  = max_u(N_IN, N_HID);
    localparam int unsigned CIW = calc_iw(N_OUT);
    localparam int unsigned IW  = calc_iw(max_u(N_HID, N_OUT));

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [N_IN-1:0]       in_q, in_d;
    logic [N_HID-1:0]      hid_stage_q, hid_stage_d;
    logic [N_OUT-1:0]      out_stage_q, out_stage_d;
    logic signed [SW-1:0]  best_score_q, best_score_d;
    logic [CIW-1:0]        best_idx_q, best_idx_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic [N_HID-1:0]      hidden_q, hidden_d;
    logic [N_OUT-1:0]      out_act_q, out_act_d;
    logic [CIW-1:0]        class_idx_q, class_idx_d;
    logic signed [SW-1:0]  class_score_q, class_score_d;

    logic [PW-1:0]         pc_a, pc_w, pc_mask;
    logic [CW-1:0]         pc_cnt;
    logic [BIAS_W-1:0]     bias;
    logic signed [SW-1:0]  score;
    logic                  act;

    bnn_xnor_popcount #(
        .WIDTH (PW)
    ) u_popcount (
        .a     (pc_a),
        .w     (pc_w),
        .mask  (pc_mask),
        .count (pc_cnt)
    );

    // Operand mux: select the current neuron's inputs, weights and bias for the active layer.
    always_comb begin
        pc_a    = '0;
        pc_w    = '0;
        pc_mask = '0;
        bias    = '0;
        if (state_q == StOut) begin
            pc_a[N_HID-1:0]    = hid_stage_q;
            pc_w[N_HID-1:0]    = bus.w_ho[idx_q*N_HID +: N_HID];
            pc_mask[N_HID-1:0] = '1;
            bias               = bus.b_o[idx_q*BIAS_W +: BIAS_W];
        end else begin
            pc_a[N_IN-1:0]     = in_q;
            pc_w[N_IN-1:0]     = bus.w_ih[idx_q*N_IN +: N_IN];
            pc_mask[N_IN-1:0]  = '1;
            bias               = bus.b_h[idx_q*BIAS_W +: BIAS_W];
        end
        score = $signed({{(SW-CW){1'b0}}, pc_cnt})
              + $signed({{(SW-BIAS_W){bias[BIAS_W-1]}}, bias});
        act   = ~score[SW-1];
    end

    // Next-state logic: sequencing, staging, running argmax and result publication.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        in_d          = in_q;
        hid_stage_d   = hid_stage_q;
        out_stage_d   = out_stage_q;
        best_score_d  = best_score_q;
        best_idx_d    = best_idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        valid_d       = valid_q;
        hidden_d      = hidden_q;
        out_act_d     = out_act_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    in_d    = bus.in_vec;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StHid;
                end
            end
            StHid: begin
                for (int j = 0; j < N_HID; j++) begin
                    if (idx_q == IW'(j)) hid_stage_d[j] = act;
                end
                if (idx_q == IW'(N_HID - 1)) begin
                    idx_d   = '0;
                    state_d = StOut;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StOut: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (idx_q == IW'(k)) out_stage_d[k] = act;
                end
                // Strictly greater keeps the lower index on ties.
                if (idx_q == '0 || score > best_score_q) begin
                    best_score_d = score;
                    best_idx_d   = CIW'(idx_q);
                end
                if (idx_q == IW'(N_OUT - 1)) begin
                    state_d       = StDone;
                    done_d        = 1'b1;
                    valid_d       = 1'b1;
                    hidden_d      = hid_stage_q;
                    out_act_d     = out_stage_d;
                    class_idx_d   = best_idx_d;
                    class_score_d = best_score_d;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and published-result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            in_q          <= '0;
            hid_stage_q   <= '0;
            out_stage_q   <= '0;
            best_score_q  <= '0;
            best_idx_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            hidden_q      <= '0;
            out_act_q     <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            in_q          <= in_d;
            hid_stage_q   <= hid_stage_d;
            out_stage_q   <= out_stage_d;
            best_score_q  <= best_score_d;
            best_idx_q    <= best_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            valid_q       <= valid_d;
            hidden_q      <= hidden_d;
            out_act_q     <= out_act_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.valid       = valid_q;
    assign bus.hidden      = hidden_q;
    assign bus.out_act     = out_act_q;
    assign bus.class_idx   = class_idx_q;
    assign bus.class_score = class_score_q;

endmodule
